// File: rtl/eth_regport_pkg.sv
// Shared constants, FSM state type and address-window helper for the
// CtrlPort-to-register-port initiator.
package eth_regport_pkg;

  localparam logic [1:0] CTRLPORT_STS_OKAY   = 2'd0;
  localparam logic [1:0] CTRLPORT_STS_CMDERR = 2'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  // True when addr falls in the 2^awidth-byte window that starts at base.
  function automatic logic window_match(input logic [19:0] addr,
                                        input logic [19:0] base,
                                        input int          awidth);
    logic [19:0] mask;
    mask = ~((20'd1 << awidth) - 20'd1);
    return ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/eth_regport_initiator.sv
// Bridges CtrlPort requests onto a pulsed register port (write/read strobes,
// read response with timeout) and returns a CtrlPort ack with status.
module eth_regport_initiator
  import eth_regport_pkg::*;
#(
  parameter int          REG_AWIDTH = 14,
  parameter logic [19:0] BASE       = 20'h00000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst,
  input  logic                  s_ctrlport_req_wr,
  input  logic                  s_ctrlport_req_rd,
  input  logic [19:0]           s_ctrlport_req_addr,
  input  logic [31:0]           s_ctrlport_req_data,
  output logic                  s_ctrlport_resp_ack,
  output logic [1:0]            s_ctrlport_resp_status,
  output logic [31:0]           s_ctrlport_resp_data,
  output logic                  reg_wr_req,
  output logic [REG_AWIDTH-1:0] reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic                  reg_rd_req,
  output logic [REG_AWIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_resp,
  input  logic [31:0]           reg_rd_data,
  output logic                  req_dropped
);

  localparam int            CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            ack_s;
  logic [1:0]      status_s;
  logic [31:0]     data_s;
  logic            wr_req_s;
  logic            rd_req_s;
  logic            load_wr_s;
  logic            load_rd_s;
  logic            dropped_s;
  logic            in_win_s;
  logic            req_any_s;

  assign in_win_s  = window_match(s_ctrlport_req_addr, BASE, REG_AWIDTH);
  assign req_any_s = s_ctrlport_req_wr | s_ctrlport_req_rd;

  // Next-state and next-output decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ack_s     = 1'b0;
    status_s  = CTRLPORT_STS_OKAY;
    data_s    = 32'h0000_0000;
    wr_req_s  = 1'b0;
    rd_req_s  = 1'b0;
    load_wr_s = 1'b0;
    load_rd_s = 1'b0;
    dropped_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_ctrlport_req_wr && s_ctrlport_req_rd) begin
          ack_s    = 1'b1;
          status_s = CTRLPORT_STS_CMDERR;
        end else if (s_ctrlport_req_wr) begin
          if (in_win_s) begin
            wr_req_s  = 1'b1;
            load_wr_s = 1'b1;
            state_s   = WR_ACK;
          end else begin
            ack_s    = 1'b1;
            status_s = CTRLPORT_STS_CMDERR;
          end
        end else if (s_ctrlport_req_rd) begin
          if (in_win_s) begin
            rd_req_s  = 1'b1;
            load_rd_s = 1'b1;
            cnt_s     = {CW{1'b0}};
            state_s   = RD_WAIT;
          end else begin
            ack_s    = 1'b1;
            status_s = CTRLPORT_STS_CMDERR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_ACK: begin
        dropped_s = req_any_s;
        ack_s     = 1'b1;
        state_s   = IDLE;
      end
      RD_WAIT: begin
        dropped_s = req_any_s;
        // A response in the timeout cycle still wins; counting starts after the strobe cycle.
        if (reg_rd_resp) begin
          ack_s   = 1'b1;
          data_s  = reg_rd_data;
          state_s = RESP;
        end else if (cnt_r == TIMEOUT_C) begin
          ack_s    = 1'b1;
          status_s = CTRLPORT_STS_CMDERR;
          state_s  = RESP;
        end else if (!reg_rd_req) begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
      end
      RESP: begin
        dropped_s = req_any_s;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs; register-port address/data hold until the next accepted request.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      s_ctrlport_resp_ack    <= 1'b0;
      s_ctrlport_resp_status <= CTRLPORT_STS_OKAY;
      s_ctrlport_resp_data   <= 32'h0000_0000;
      reg_wr_req             <= 1'b0;
      reg_rd_req             <= 1'b0;
      reg_wr_addr            <= {REG_AWIDTH{1'b0}};
      reg_wr_data            <= 32'h0000_0000;
      reg_rd_addr            <= {REG_AWIDTH{1'b0}};
      req_dropped            <= 1'b0;
    end else begin
      s_ctrlport_resp_ack    <= ack_s;
      s_ctrlport_resp_status <= status_s;
      s_ctrlport_resp_data   <= data_s;
      reg_wr_req             <= wr_req_s;
      reg_rd_req             <= rd_req_s;
      req_dropped            <= dropped_s;
      if (load_wr_s) begin
        reg_wr_addr <= s_ctrlport_req_addr[REG_AWIDTH-1:0];
        reg_wr_data <= s_ctrlport_req_data;
      end
      if (load_rd_s) begin
        reg_rd_addr <= s_ctrlport_req_addr[REG_AWIDTH-1:0];
      end
    end
  end

endmodule
